// File: rtl/run_ctrl_pkg.sv
// Shared types for the run/step sequencer.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    HALT       = 2'd1,
    STEP       = 2'd2,
    RUN        = 2'd3
  } state_t;

  function automatic logic dp_en_of(state_t s);
    return (s == STEP) || (s == RUN);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Button synchronizer, debouncer and press detector.
// Emits a single-cycle o_press per accepted rising level.
module button_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_button,
  output logic o_press
);

  logic        sync1;
  logic        sync2;
  logic        lvl;
  logic        lvl_q;
  logic [15:0] cnt;
  logic        stable_done;

  assign stable_done = (cnt == DEBOUNCE_CYCLES - 16'd1);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      lvl     <= 1'b0;
      lvl_q   <= 1'b0;
      cnt     <= '0;
      o_press <= 1'b0;
    end else begin
      sync1   <= i_button;
      sync2   <= sync1;
      lvl_q   <= lvl;
      o_press <= lvl & ~lvl_q;
      // any return to the accepted level restarts the count
      if (sync2 == lvl) begin
        cnt <= '0;
      end else if (stable_done) begin
        lvl <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run/step sequencer gating the datapath clock enable.
// Define RUN_CTRL_INSTR_CNT_EN to build the instruction counter.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES   = 16'd50000,
  parameter logic [7:0]  RESET_HOLD_CYCLES = 8'd16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_button,
  input  logic        i_run_mode,
  input  logic        i_instr_done,
  input  logic        i_halt,
  output logic        o_dp_reset,
  output logic        o_dp_en,
  output logic [1:0]  o_state,
  output logic [31:0] o_instr_cnt
);

  logic       press;
  logic       rm_s1;
  logic       rm_s;
  state_t     state;
  state_t     state_nxt;
  logic [7:0] hold_cnt;
  logic [7:0] hold_nxt;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_button (i_button),
    .o_press  (press)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rm_s1    <= 1'b0;
      rm_s     <= 1'b0;
      state    <= RESET_HOLD;
      hold_cnt <= '0;
    end else begin
      rm_s1    <= i_run_mode;
      rm_s     <= rm_s1;
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    unique case (state)
      RESET_HOLD: begin
        if (hold_cnt == RESET_HOLD_CYCLES - 8'd1) begin
          state_nxt = HALT;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      HALT: begin
        // a halted CPU can only be left via reset
        if (press && !i_halt)
          state_nxt = rm_s ? RUN : STEP;
      end
      STEP: begin
        if (i_halt || i_instr_done)
          state_nxt = HALT;
      end
      RUN: begin
        if (i_halt || press)
          state_nxt = HALT;
        else if (!rm_s)
          state_nxt = STEP;
      end
    endcase
  end

  assign o_dp_reset = (state == RESET_HOLD);
  assign o_dp_en    = dp_en_of(state);
  assign o_state    = state;

`ifdef RUN_CTRL_INSTR_CNT_EN
  logic [31:0] instr_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      instr_cnt <= '0;
    else if (state == RESET_HOLD)
      instr_cnt <= '0;
    else if (o_dp_en && i_instr_done)
      instr_cnt <= instr_cnt + 32'd1;
  end

  assign o_instr_cnt = instr_cnt;
`else
  assign o_instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Directed and randomized bench for run_ctrl against a behavioural model.
module tb_run_ctrl;
  import run_ctrl_pkg::*;

  localparam int D = 4;
  localparam int H = 8;
`ifdef RUN_CTRL_INSTR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn;
  logic        rm;
  logic        done;
  logic        halt;
  logic        o_dp_reset;
  logic        o_dp_en;
  logic [1:0]  o_state;
  logic [31:0] o_instr_cnt;

  int checks = 0;
  int errors = 0;

  run_ctrl #(
    .DEBOUNCE_CYCLES  (16'd4),
    .RESET_HOLD_CYCLES(8'd8)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_button    (btn),
    .i_run_mode  (rm),
    .i_instr_done(done),
    .i_halt      (halt),
    .o_dp_reset  (o_dp_reset),
    .o_dp_en     (o_dp_en),
    .o_state     (o_state),
    .o_instr_cnt (o_instr_cnt)
  );

  always #5 clk = ~clk;

  // behavioural model
  state_t      m_state;
  int          m_hold;
  logic [31:0] m_cnt;
  logic        m_b1, m_b2, m_r1, m_r2;
  logic        m_lvl, m_lvl_q, m_press;
  logic        win[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = RESET_HOLD;
    m_hold  = 0;
    m_cnt   = 0;
    m_b1 = 0; m_b2 = 0; m_r1 = 0; m_r2 = 0;
    m_lvl = 0; m_lvl_q = 0; m_press = 0;
    win.delete();
  endtask

  task automatic model_edge();
    state_t nxt;
    logic   bs;
    logic   same;
    if (!rst_n) begin
      model_reset();
      return;
    end
    nxt = m_state;
    case (m_state)
      RESET_HOLD: begin
        m_hold++;
        if (m_hold >= H) begin
          nxt = HALT;
          m_hold = 0;
        end
      end
      HALT: if (m_press && !halt) nxt = m_r2 ? RUN : STEP;
      STEP: if (halt || done) nxt = HALT;
      RUN: begin
        if (halt || m_press) nxt = HALT;
        else if (!m_r2) nxt = STEP;
      end
      default: nxt = m_state;
    endcase
    if (CNT_ON) begin
      if (m_state == RESET_HOLD) m_cnt = 0;
      else if ((m_state == STEP || m_state == RUN) && done)
        m_cnt = m_cnt + 1;
    end
    bs = m_b2; m_b2 = m_b1; m_b1 = btn;
    m_r2 = m_r1; m_r1 = rm;
    m_press = m_lvl && !m_lvl_q;
    m_lvl_q = m_lvl;
    // level accepted after D consecutive equal synced samples
    win.push_back(bs);
    if (win.size() > D) void'(win.pop_front());
    if (win.size() == D) begin
      same = 1'b1;
      foreach (win[i]) if (win[i] != bs) same = 1'b0;
      if (same && bs != m_lvl) m_lvl = bs;
    end
    m_state = nxt;
  endtask

  task automatic compare();
    chk("state", {30'd0, o_state}, {30'd0, m_state});
    chk("dp_en", {31'd0, o_dp_en},
        {31'd0, (m_state == STEP || m_state == RUN)});
    chk("dp_reset", {31'd0, o_dp_reset},
        {31'd0, (m_state == RESET_HOLD)});
    chk("instr_cnt", o_instr_cnt, m_cnt);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic press_wait();
    logic [1:0] s0;
    int n;
    btn = 0;
    repeat (8) cyc();
    s0 = o_state;
    btn = 1;
    n = 0;
    while (o_state == s0 && n < 30) begin
      cyc();
      n++;
    end
    btn = 0;
    chk("press_seen", {31'd0, (n < 30)}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 0;
    cyc();
    rst_n = 1;
    repeat (H) cyc();
  endtask

  initial begin
    int n;
    rst_n = 0; btn = 0; rm = 0; done = 0; halt = 0;
    model_reset();

    // 1: reset values and reset hold
    #1;
    chk("rst_state", {30'd0, o_state}, 32'd0);
    chk("rst_dp_reset", {31'd0, o_dp_reset}, 32'd1);
    chk("rst_dp_en", {31'd0, o_dp_en}, 32'd0);
    chk("rst_cnt", o_instr_cnt, 32'd0);
    @(negedge clk);
    cyc();
    rst_n = 1;
    repeat (H - 1) cyc();
    chk("hold_last", {31'd0, o_dp_reset}, 32'd1);
    cyc();
    chk("hold_done", {30'd0, o_state}, {30'd0, HALT});
    chk("hold_en", {31'd0, o_dp_en}, 32'd0);

    // 2: bouncing button gives one press
    repeat (4) cyc();
    for (int i = 0; i < 6; i++) begin
      btn = (i % 2 == 0);
      cyc();
    end
    btn = 1;
    n = 0;
    while (o_state == HALT && n < 30) begin
      cyc();
      n++;
    end
    chk("press_lat", n, 32'd8);
    chk("bounce_step", {30'd0, o_state}, {30'd0, STEP});
    halt = 1;
    cyc();
    halt = 0;
    repeat (11) cyc();
    chk("held_once", {30'd0, o_state}, {30'd0, HALT});
    btn = 0;
    repeat (10) cyc();
    btn = 1;
    repeat (3) cyc();
    btn = 0;
    repeat (12) cyc();
    chk("short_nopress", {30'd0, o_state}, {30'd0, HALT});

    // 3: single step of a 4-cycle instruction
    rm = 0;
    press_wait();
    for (int k = 1; k <= 4; k++) begin
      chk("step_en", {31'd0, o_dp_en}, 32'd1);
      done = (k == 4);
      cyc();
    end
    done = 0;
    chk("step_off", {31'd0, o_dp_en}, 32'd0);
    chk("step_halt", {30'd0, o_state}, {30'd0, HALT});
    chk("step_cnt", o_instr_cnt, CNT_ON ? 32'd1 : 32'd0);

    // 4: free run, three instructions, pause
    do_reset();
    rm = 1;
    press_wait();
    chk("run_enter", {30'd0, o_state}, {30'd0, RUN});
    for (int p = 0; p < 3; p++) begin
      repeat (2) cyc();
      done = 1;
      cyc();
      done = 0;
    end
    press_wait();
    chk("run_pause", {30'd0, o_state}, {30'd0, HALT});
    chk("run_cnt", o_instr_cnt, CNT_ON ? 32'd3 : 32'd0);

    // 5: halt together with press, then halted
    press_wait();
    repeat (8) cyc();
    btn = 1;
    repeat (7) cyc();
    halt = 1;
    cyc();
    chk("halt_press", {30'd0, o_state}, {30'd0, HALT});
    repeat (6) cyc();
    btn = 0;
    repeat (8) cyc();
    btn = 1;
    repeat (12) cyc();
    btn = 0;
    repeat (4) cyc();
    chk("halted_stay", {30'd0, o_state}, {30'd0, HALT});
    chk("halted_en", {31'd0, o_dp_en}, 32'd0);

    // 6: asynchronous reset mid-instruction
    do_reset();
    halt = 0;
    press_wait();
    done = 1;
    cyc();
    done = 0;
    cyc();
    #2 rst_n = 0;
    #1;
    chk("arst_en", {31'd0, o_dp_en}, 32'd0);
    chk("arst_reset", {31'd0, o_dp_reset}, 32'd1);
    chk("arst_cnt", o_instr_cnt, 32'd0);
    model_reset();
    cyc();
    rst_n = 1;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(11) == 0) btn = ~btn;
      if ($urandom_range(99) == 0) rm = ~rm;
      halt = ($urandom_range(59) == 0);
      done = ($urandom_range(3) == 0);
      rst_n = ($urandom_range(599) != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
